// File: rtl/sym_pkg.sv
// ----------------------------------------------------------------------------
// sym_pkg
// Shared constants and types for the serial-to-byte deserializer.
//   BYTE_W     : width of an assembled data byte
//   FRAME_BITS : serial bits per frame (8 data, plus 1 even-parity bit when
//                SYM_DESER_PARITY_EN is defined)
//   CNT_W      : width of the in-frame bit counter
//   sym_state_e: shifter state (IDLE = no bits held, SHIFT = partial frame)
// Configuration macro: SYM_DESER_PARITY_EN
// ----------------------------------------------------------------------------
package sym_pkg;

  localparam int BYTE_W = 8;

`ifdef SYM_DESER_PARITY_EN
  localparam int FRAME_BITS = BYTE_W + 1;
`else
  localparam int FRAME_BITS = BYTE_W;
`endif

  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sym_state_e;

endpackage : sym_pkg

// File: rtl/sym_shift_reg.sv
// ----------------------------------------------------------------------------
// sym_shift_reg
// Serial shifter with bit counter. Collects FRAME_BITS bits MSB first and
// raises frame_done_o (combinational) during the cycle in which the last
// bit is presented; frame_o then carries the complete frame including that
// bit, so the parent can capture it on the same clock edge.
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   bit_in_i      : serial data bit
//   bit_valid_i   : qualifies bit_in_i
//   frame_start_i : discard partial frame, restart count (beats bit_valid_i)
//   frame_done_o  : last bit of a frame is being accepted this cycle
//   frame_o       : complete frame (held bits followed by bit_in_i)
// Configuration macro: SYM_DESER_PARITY_EN (via sym_pkg::FRAME_BITS)
//
// state | meaning
// ------+-----------------------------------------
// IDLE  | no bits of a frame held (counter = 0)
// SHIFT | 1..FRAME_BITS-1 bits held
// ----------------------------------------------------------------------------
module sym_shift_reg
  import sym_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in_i,
  input  logic                  bit_valid_i,
  input  logic                  frame_start_i,
  output logic                  frame_done_o,
  output logic [FRAME_BITS-1:0] frame_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  sym_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Only FRAME_BITS-1 bits ever need holding; the last bit arrives live.
  logic [FRAME_BITS-2:0] sr_q, sr_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    frame_done_o = 1'b0;
    frame_o      = {sr_q, bit_in_i};

    if (frame_start_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (bit_valid_i) begin
      sr_d = frame_o[FRAME_BITS-2:0];
      if (state_q == SHIFT && cnt_q == LAST_CNT) begin
        frame_done_o = 1'b1;
        state_d      = IDLE;
        cnt_d        = '0;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

endmodule : sym_shift_reg

// File: rtl/sym_byte_deserializer.sv
// ----------------------------------------------------------------------------
// sym_byte_deserializer
// Assembles MSB-first serial bits into bytes and offers them to a downstream
// symmetry detector through a one-entry valid/ready output slot.
// Ports:
//   clk         : sole clock, rising edge
//   rst         : synchronous active-high reset, overrides everything
//   bit_in      : serial data bit, MSB first
//   bit_valid   : bit_in qualifier
//   frame_start : sync pulse, discards any partial frame
//   byte_out    : assembled byte
//   byte_valid  : byte_out holds an unconsumed byte
//   byte_ready  : downstream accept (transfer = byte_valid & byte_ready)
//   parity_err  : (SYM_DESER_PARITY_EN only) one-cycle pulse, frame dropped
//   overflow    : sticky, a completed byte was dropped because slot was full
//   byte_count  : number of transferred bytes, modulo 256
// Configuration macro: SYM_DESER_PARITY_EN adds a trailing even-parity bit
// to each frame and the parity_err output.
// ----------------------------------------------------------------------------
module sym_byte_deserializer
  import sym_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              frame_start,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
`ifdef SYM_DESER_PARITY_EN
  output logic              parity_err,
`endif
  output logic              overflow,
  output logic [7:0]        byte_count
);

  logic                  frame_done;
  logic [FRAME_BITS-1:0] frame;
  logic [BYTE_W-1:0]     frame_byte;
  logic                  frame_ok;

  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        count_q, count_d;
  logic              transfer;
  logic              slot_free;

  sym_shift_reg u_shift (
    .clk          (clk),
    .rst          (rst),
    .bit_in_i     (bit_in),
    .bit_valid_i  (bit_valid),
    .frame_start_i(frame_start),
    .frame_done_o (frame_done),
    .frame_o      (frame)
  );

`ifdef SYM_DESER_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign frame_byte = frame[FRAME_BITS-1:1];
  assign frame_ok   = ~(^frame);
`else
  assign frame_byte = frame;
  assign frame_ok   = 1'b1;
`endif

  assign transfer  = valid_q & byte_ready;
  // A transfer on the completing edge frees the slot for the new byte.
  assign slot_free = ~valid_q | transfer;

  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    if (transfer) begin
      valid_d = 1'b0;
      count_d = count_q + 8'd1;
    end

    if (frame_done && frame_ok) begin
      if (slot_free) begin
        byte_d  = frame_byte;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

`ifdef SYM_DESER_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= frame_done & ~frame_ok;
    end
  end

  assign parity_err = perr_q;
`endif

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign overflow   = ovf_q;
  assign byte_count = count_q;

endmodule : sym_byte_deserializer

// File: doc/sym_byte_deserializer.md
SYM_BYTE_DESERIALIZER -- requirements
Module: sym_byte_deserializer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port bit_in, input, 1, serial data bit, MSB first.
REQ-004 SHALL have port bit_valid, input, 1, bit_in qualifier, sampled each clk edge.
REQ-005 SHALL have port frame_start, input, 1, sync pulse: discard partial byte, restart count.
REQ-006 SHALL have port byte_out, output, 8, assembled byte to downstream symmetry detector.
REQ-007 SHALL have port byte_valid, output, 1, byte_out holds an unconsumed byte.
REQ-008 SHALL have port byte_ready, input, 1, downstream accept; transfer when byte_valid and byte_ready are both high at a clk edge.
REQ-009 SHALL have port overflow, output, 1, sticky; a completed byte was dropped.
REQ-010 SHALL have port byte_count, output, 8, completed-and-accepted byte counter, wraps 255->0.

Function
REQ-011 SHALL keep shift state machine IDLE (0 bits held) / SHIFT (1..7 bits held) plus 3-bit bit counter.
REQ-012 SHALL shift bit_in into shift register LSB, prior bits move toward MSB, on each edge with bit_valid=1.
REQ-013 SHALL, on the edge accepting the 8th bit, return to IDLE and load byte_out; byte_valid high next cycle (latency 1 cycle after 8th bit).
REQ-014 SHALL hold byte_out and byte_valid stable until transfer; byte_valid drops on transfer edge unless a new byte loads on same edge.
REQ-015 SHALL treat output slot as free if byte_valid=0 or transfer occurs on the same edge as the 8th bit (back-to-back, no bubble).
REQ-016 SHALL, if 8th bit completes while slot full and not transferring, drop new byte, keep old byte_out, set overflow.
REQ-017 SHALL give frame_start priority over bit_valid: counter cleared, state IDLE, bit on that cycle discarded; output slot untouched.
REQ-018 SHALL increment byte_count by 1 per transfer, modulo 256.
REQ-019 SHALL ignore bit_in when bit_valid=0; state unchanged.

Reset
REQ-020 SHALL on rst=1: state IDLE, counter 0, shift register 0, byte_out 8'h00, byte_valid 0, overflow 0, byte_count 0.
REQ-021 SHALL let reset override all other inputs, including mid-shift and pending unconsumed byte (byte lost, not flagged).
REQ-022 SHALL clear overflow only by reset.

Configuration
REQ-023 SHALL support macro SYM_DESER_PARITY_EN.
REQ-024 With SYM_DESER_PARITY_EN defined: frame is 9 bits, 8 data then even-parity bit; extra output parity_err (1 bit) pulses high one cycle, byte dropped, on mismatch; byte loads only when parity matches.
REQ-025 Without macro: 8-bit frames, no parity_err port, no parity logic.

Structure
REQ-026 SHALL place BYTE_W=8, state enum (IDLE, SHIFT) and FRAME_BITS constant (8 or 9 per macro) in shared package sym_pkg.
REQ-027 SHALL instantiate one sub-module sym_shift_reg (shift register plus bit counter, frame-done strobe); handshake, overflow, byte_count in top.

Verification
REQ-028 Reset, then bits 1,0,0,1,1,0,0,1 on 8 consecutive cycles, byte_ready=1 -> byte_out=8'h99, byte_valid high exactly 1 cycle, byte_count=1.
REQ-029 Byte 8'hA5 with byte_ready=0 for 5 cycles -> byte_out stable 8'hA5, byte_valid held; raise ready -> one transfer, byte_count+1.
REQ-030 16 continuous bits 8'h3C,8'hC3, ready=1 -> both bytes delivered back-to-back, no gap, overflow=0.
REQ-031 Byte 8'h81 unaccepted, then 8 more bits 8'hFF -> byte_out stays 8'h81, overflow=1 persistent until rst.
REQ-032 4 bits, frame_start pulse, then 8 bits of 8'h18 -> byte_out=8'h18 (partial discarded).
REQ-033 rst asserted after 5 bits, then 8 bits of 8'h7E -> byte_out=8'h7E; with SYM_DESER_PARITY_EN, 8'h7E+parity 1 -> parity_err pulse, no byte_valid.
